// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-read, single-write register file.
//
// The array has no reset. After reset a clear sequencer writes zero to every
// entry, one per cycle. While that sweep runs, busy is high, writes are dropped
// and every read port returns zero.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous reset, active-low; restarts the clear sweep from entry 0
//   we       write enable (honoured only in RUN)
//   wbe      byte-lane write enables; lane i covers bits [8i+7:8i]
//   wa       write address; writes to wa >= DEPTH, or to entry 0 when ZERO_REG=1,
//            are dropped
//   wd       write data
//   ra       packed read addresses; port p uses ra[p*AW +: AW]
//   rd       packed read data; port p drives rd[p*WIDTH +: WIDTH]
//   busy     high while the clear sweep runs
//
// Parameters: WIDTH (multiple of 8), DEPTH (any value <= 2**AW), AW, NRD (1..4),
//   BYPASS (a same-cycle write shows on the matching read port),
//   ZERO_REG (entry 0 reads as zero and ignores writes).
module regfile_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [WIDTH/8-1:0]     wbe,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NRD*AW-1:0]      ra,
  output logic [NRD*WIDTH-1:0]   rd,
  output logic                   busy
);

  localparam int unsigned NB = WIDTH / 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_reg;
  logic [AW-1:0]     clr_ptr_reg;
  logic              busy_reg;

  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  // Expand the byte enables into a bit mask once. It is shared by the
  // write path and by the bypass merge.
  logic [WIDTH-1:0]  wmask;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign wmask[8*gi +: 8] = {8{wbe[gi]}};
    end
  endgenerate

  // A functional write needs RUN, an in-range address and a writable entry.
  logic wa_in_range;
  logic wa_is_zero;
  logic wr_ok;

  assign wa_in_range = (32'(wa) < DEPTH);
  assign wa_is_zero  = (ZERO_REG != 0) && (wa == '0);
  assign wr_ok       = we && (state_reg == RUN) && wa_in_range && !wa_is_zero;

  // Sequencer: CLEAR sweeps the entries 0..DEPTH-1, then the block stays in RUN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (clr_ptr_reg == LAST_ADDR) begin
            state_reg <= RUN;
            busy_reg  <= 1'b0;
          end else begin
            clr_ptr_reg <= clr_ptr_reg + AW'(1);
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg   <= CLEAR;
          clr_ptr_reg <= '0;
          busy_reg    <= 1'b1;
        end
      endcase
    end
  end

  // The sweep and the functional write share one array write port. The clear
  // step writes a full-width zero. No write is done while reset_n is low.
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_mask;
  logic [WIDTH-1:0]  mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wa;
    mem_mask  = wmask;
    mem_wdata = wd;
    if (reset_n) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_reg;
        mem_mask  = '1;
        mem_wdata = '0;
      end else if (wr_ok && (wbe != '0)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= (mem[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
    end
  end

  // Read ports are combinational. Each port returns zero when any of these
  // holds: the sweep is running, the address is out of range, or the address
  // is the hardwired-zero entry.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]    raddr;
      logic             r_in_range;
      logic             r_is_zero;
      logic [WIDTH-1:0] stored;
      logic [WIDTH-1:0] value;

      assign raddr      = ra[gi*AW +: AW];
      assign r_in_range = (32'(raddr) < DEPTH);
      assign r_is_zero  = (ZERO_REG != 0) && (raddr == '0);

      always_comb begin
        stored = '0;
        if (r_in_range) begin
          stored = mem[raddr];
        end
        value = stored;
        // Bypass merges only the enabled lanes of wd over the stored word.
        if ((BYPASS != 0) && wr_ok && (wa == raddr)) begin
          value = (stored & ~wmask) | (wd & wmask);
        end
        if ((state_reg == CLEAR) || !r_in_range || r_is_zero) begin
          value = '0;
        end
      end

      assign rd[gi*WIDTH +: WIDTH] = value;
    end
  endgenerate

  assign busy = busy_reg;

endmodule
